// File: rtl/shift_left_seq_pkg.sv
// shift_left_seq_pkg: shared state encoding and sizing helper for the sequential left shifter
package shift_left_seq_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/shift_left_stage.sv
// shift_left_stage: one log-stage of the left shifter, shifting by 2**idx when enabled
module shift_left_stage
    import shift_left_seq_pkg::*;
#(
    parameter int Nbits = 4,
    parameter int CW    = cnt_width(Nbits)
) (
    input  logic [Nbits-1:0] data,
    input  logic [CW-1:0]    idx,
    input  logic             en,
    output logic [Nbits-1:0] shifted,
    output logic             carry
);

    int               sh;
    logic [Nbits-1:0] moved;
    logic [Nbits-1:0] one;

    // shift distance and the last bit pushed past the MSB; distances beyond the width drop everything
    always_comb begin
        sh    = 1 << idx;
        one   = Nbits'(1);
        moved = data << sh;
        carry = en && (sh <= Nbits) && (|(data & (one << (Nbits - sh))));
    end

    for (genvar i = 0; i < Nbits; i++) begin : g_mux
        assign shifted[i] = en ? moved[i] : data[i];
    end

endmodule

// File: rtl/shift_left_seq.sv
// shift_left_seq: multi-cycle logical left shifter, one log-stage per clock, valid/ready on both sides
module shift_left_seq
    import shift_left_seq_pkg::*;
#(
    parameter int Nbits = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Nbits-1:0] a,
    input  logic [Nbits-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Nbits-1:0] out,
    output logic             carry,
    output logic             zero
);

    localparam int CW = cnt_width(Nbits);

    shift_state_t     state;
    shift_state_t     state_nxt;
    logic [Nbits-1:0] data;
    logic [Nbits-1:0] amt;
    logic [Nbits-1:0] stage_data;
    logic [CW-1:0]    stage;
    logic             stage_carry;
    logic             carry_q;
    logic             zero_q;
    logic             valid_q;
    logic             last;

    assign last      = stage == CW'(Nbits - 1);
    assign out       = data;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign out_valid = valid_q;

    // amt is consumed LSB-first, so bit 0 always enables the current stage
    shift_left_stage #(.Nbits(Nbits), .CW(CW)) u_stage (
        .data    (data),
        .idx     (stage),
        .en      (amt[0]),
        .shifted (stage_data),
        .carry   (stage_carry)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state and input handshake
    always_comb begin
        state_nxt = state;
        in_ready  = state == IDLE;
        unique case (state)
            IDLE:    if (in_valid)  state_nxt = SHIFT;
            SHIFT:   if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // datapath: latch operands, apply one stage per cycle, register the result flags on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data    <= '0;
            amt     <= '0;
            stage   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    data    <= a;
                    amt     <= b;
                    carry_q <= 1'b0;
                    stage   <= '0;
                end
                SHIFT: begin
                    data  <= stage_data;
                    amt   <= amt >> 1;
                    stage <= stage + CW'(1);
                    if (amt[0]) carry_q <= stage_carry;
                    if (last) begin
                        valid_q <= 1'b1;
                        zero_q  <= stage_data == '0;
                    end
                end
                DONE: if (out_ready) valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
